// File: rtl/cnn_pkg.sv
// Shared sequencer state encoding and configuration-legality limits for the conv datapath.
package cnn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdFilt,
    StLdRow,
    StAccClr,
    StMac,
    StWrite,
    StShift,
    StDone
  } state_e;

  localparam int unsigned MinCount  = 1;
  localparam int unsigned MinStride = 1;

  function automatic logic cfg_legal(input int unsigned rows, input int unsigned cols,
                                     input int unsigned num_filt, input int unsigned stride,
                                     input int unsigned max_f, input int unsigned k);
    return (rows >= MinCount) && (cols >= MinCount) && (num_filt >= MinCount) &&
           (num_filt <= max_f) && (stride >= MinStride) && (stride <= k);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with synchronous clear; wrap_o flags the enabled step from modulus-1 back to 0.
module wrap_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width:0]   modulus_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_d, count_q;
  logic             last;

  assign last    = ({1'b0, count_q} == (modulus_i - {{Width{1'b0}}, 1'b1}));
  assign wrap_o  = en_i && last;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution sequencer: loads filter and ifmap rows slice by slice, then walks K*K taps
// per output position and hands each result off through a valid/ready write.
module conv_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned K      = 3,
  parameter int unsigned SLICES = 4,
  parameter int unsigned N_BUF  = 4,
  parameter int unsigned MAX_F  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         cfg_out_rows,
  input  logic [CNT_W-1:0]         cfg_out_cols,
  input  logic [$clog2(MAX_F):0]   cfg_num_filt,
  input  logic [1:0]               cfg_stride,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ld_filt,
  output logic [$clog2(N_BUF)-1:0] buf_sel,
  output logic [SLICES-1:0]        slice_we,
  output logic [$clog2(N_BUF)-1:0] win_base,
  output logic [$clog2(K)-1:0]     tap_row,
  output logic [$clog2(K)-1:0]     tap_col,
  output logic                     win_shift,
  output logic                     acc_clr,
  output logic                     mac_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(MAX_F)-1:0] out_filt,
  output logic [CNT_W-1:0]         out_row,
  output logic [CNT_W-1:0]         out_col,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int unsigned TW  = $clog2(K);
  localparam int unsigned TW1 = TW + 1;
  localparam int unsigned SW  = $clog2(SLICES);
  localparam int unsigned BW  = $clog2(N_BUF);
  localparam int unsigned FW  = $clog2(MAX_F);
  localparam logic [SW:0]    SliceMod = SLICES[SW:0];
  localparam logic [TW:0]    KMod     = K[TW:0];
  localparam logic [BW-1:0]  BufLast  = BW'(N_BUF - 1);

  state_e              state_d, state_q;
  logic [CNT_W-1:0]    rows_d, rows_q, cols_d, cols_q;
  logic [FW:0]         nf_d, nf_q;
  logic [1:0]          stride_d, stride_q;
  logic                cfg_err_d, cfg_err_q;
  logic [BW-1:0]       wr_ptr_d, wr_ptr_q, win_base_d, win_base_q;

  logic                loading, beat, start_ok, legal;
  logic [SW-1:0]       slice_cnt;
  logic [TW-1:0]       aux_cnt, tcol_cnt, trow_cnt;
  logic [TW:0]         aux_mod;
  logic                slice_wrap, aux_en, aux_wrap, tcol_wrap, trow_wrap;
  logic                pos_en, col_wrap, row_wrap, filt_wrap;
  logic [CNT_W-1:0]    col_cnt, row_cnt;
  logic [FW-1:0]       filt_cnt;

  assign loading  = (state_q == StLdFilt) || (state_q == StLdRow);
  assign beat     = loading && in_valid;
  assign start_ok = (state_q == StIdle) && start;
  assign legal    = cfg_legal(32'(cfg_out_rows), 32'(cfg_out_cols), 32'(cfg_num_filt),
                              32'(cfg_stride), MAX_F, K);

  // One row is K slices-rows on a fresh window, otherwise only the stride's worth of new rows.
  assign aux_mod = ((state_q == StLdFilt) || ((state_q == StLdRow) && (row_cnt == '0))) ?
                   KMod : TW1'(stride_q);
  assign aux_en  = (loading && slice_wrap) || (state_q == StShift);
  assign pos_en  = (state_q == StWrite) && out_ready;

  wrap_counter #(.Width(SW)) u_slice_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start_ok), .en_i(beat), .modulus_i(SliceMod),
    .count_o(slice_cnt), .wrap_o(slice_wrap)
  );

  wrap_counter #(.Width(TW)) u_aux_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start_ok), .en_i(aux_en), .modulus_i(aux_mod),
    .count_o(aux_cnt), .wrap_o(aux_wrap)
  );

  wrap_counter #(.Width(TW)) u_tcol_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start_ok), .en_i(state_q == StMac), .modulus_i(KMod),
    .count_o(tcol_cnt), .wrap_o(tcol_wrap)
  );

  wrap_counter #(.Width(TW)) u_trow_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start_ok), .en_i(tcol_wrap), .modulus_i(KMod),
    .count_o(trow_cnt), .wrap_o(trow_wrap)
  );

  wrap_counter #(.Width(CNT_W)) u_col_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start_ok), .en_i(pos_en), .modulus_i({1'b0, cols_q}),
    .count_o(col_cnt), .wrap_o(col_wrap)
  );

  wrap_counter #(.Width(CNT_W)) u_row_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start_ok), .en_i(col_wrap), .modulus_i({1'b0, rows_q}),
    .count_o(row_cnt), .wrap_o(row_wrap)
  );

  wrap_counter #(.Width(FW)) u_filt_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(start_ok), .en_i(row_wrap), .modulus_i(nf_q),
    .count_o(filt_cnt), .wrap_o(filt_wrap)
  );

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    nf_d       = nf_q;
    stride_d   = stride_q;
    cfg_err_d  = cfg_err_q;
    wr_ptr_d   = wr_ptr_q;
    win_base_d = win_base_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d     = cfg_out_rows;
          cols_d     = cfg_out_cols;
          nf_d       = cfg_num_filt;
          stride_d   = cfg_stride;
          cfg_err_d  = !legal;
          wr_ptr_d   = '0;
          win_base_d = '0;
          state_d    = legal ? StLdFilt : StDone;
        end
      end
      StLdFilt: if (aux_wrap) state_d = StLdRow;
      StLdRow: begin
        if (slice_wrap) wr_ptr_d = (wr_ptr_q == BufLast) ? '0 : wr_ptr_q + BW'(1);
        if (aux_wrap) begin
          state_d = StAccClr;
          if (row_cnt != '0) begin
            win_base_d = BW'((32'(win_base_q) + 32'(stride_q)) % N_BUF);
          end
        end
      end
      StAccClr: state_d = StMac;
      StMac:    if (trow_wrap) state_d = StWrite;
      StWrite: begin
        if (out_ready) begin
          if (!col_wrap) begin
            state_d = StShift;
          end else if (!row_wrap) begin
            state_d = StLdRow;
          end else if (!filt_wrap) begin
            state_d    = StLdFilt;
            wr_ptr_d   = '0;
            win_base_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: if (aux_wrap) state_d = StAccClr;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = loading;
    ld_filt   = (state_q == StLdFilt);
    slice_we  = beat ? (SLICES'(1) << (SW'(SLICES - 1) - slice_cnt)) : '0;
    buf_sel   = '0;
    if (state_q == StLdFilt) buf_sel = BW'(aux_cnt);
    if (state_q == StLdRow)  buf_sel = wr_ptr_q;
    win_base  = win_base_q;
    tap_row   = trow_cnt;
    tap_col   = tcol_cnt;
    win_shift = (state_q == StShift);
    acc_clr   = (state_q == StAccClr);
    mac_en    = (state_q == StMac);
    out_valid = (state_q == StWrite);
    out_filt  = filt_cnt;
    out_row   = row_cnt;
    out_col   = col_cnt;
    busy      = (state_q != StIdle) && (state_q != StDone);
    done      = (state_q == StDone);
    cfg_err   = cfg_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rows_q     <= '0;
      cols_q     <= '0;
      nf_q       <= '0;
      stride_q   <= '0;
      cfg_err_q  <= 1'b0;
      wr_ptr_q   <= '0;
      win_base_q <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      nf_q       <= nf_d;
      stride_q   <= stride_d;
      cfg_err_q  <= cfg_err_d;
      wr_ptr_q   <= wr_ptr_d;
      win_base_q <= win_base_d;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: cycle-exact timelines for load, MAC, write, shift and errors.
module tb_conv_sequencer;

  localparam int unsigned K = 3, SLICES = 4, N_BUF = 4, MAX_F = 8, CNT_W = 8;

  localparam logic [7:0] CIdle = 8'b0000_0000;
  localparam logic [7:0] CLdF  = 8'b1100_0010;
  localparam logic [7:0] CLdR  = 8'b1000_0010;
  localparam logic [7:0] CAcc  = 8'b0010_0010;
  localparam logic [7:0] CMac  = 8'b0001_0010;
  localparam logic [7:0] CWr   = 8'b0000_1010;
  localparam logic [7:0] CDn   = 8'b0000_0100;
  localparam logic [7:0] CSh   = 8'b0000_0011;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CNT_W-1:0] cfg_out_rows = 8'd1, cfg_out_cols = 8'd1;
  logic [3:0]       cfg_num_filt = 4'd1;
  logic [1:0]       cfg_stride = 2'd1;
  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic             in_ready, ld_filt, win_shift, acc_clr, mac_en, out_valid, busy, done, cfg_err;
  logic [1:0]       buf_sel, win_base, tap_row, tap_col;
  logic [3:0]       slice_we;
  logic [2:0]       out_filt;
  logic [CNT_W-1:0] out_row, out_col;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_sequencer #(.K(K), .SLICES(SLICES), .N_BUF(N_BUF), .MAX_F(MAX_F), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_out_rows(cfg_out_rows),
    .cfg_out_cols(cfg_out_cols), .cfg_num_filt(cfg_num_filt), .cfg_stride(cfg_stride),
    .in_valid(in_valid), .in_ready(in_ready), .ld_filt(ld_filt), .buf_sel(buf_sel),
    .slice_we(slice_we), .win_base(win_base), .tap_row(tap_row), .tap_col(tap_col),
    .win_shift(win_shift), .acc_clr(acc_clr), .mac_en(mac_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_filt(out_filt), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  function automatic logic [7:0] ctl();
    return {in_ready, ld_filt, acc_clr, mac_en, out_valid, done, busy, win_shift};
  endfunction

  function automatic logic [39:0] all_out();
    return {in_ready, ld_filt, buf_sel, slice_we, win_base, tap_row, tap_col, win_shift,
            acc_clr, mac_en, out_valid, out_filt, out_row, out_col, busy, done, cfg_err};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int r, input int c, input int nf, input int s);
    cfg_out_rows = 8'(r);
    cfg_out_cols = 8'(c);
    cfg_num_filt = 4'(nf);
    cfg_stride   = 2'(s);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; start = 1'b1;
    #2;
    checks++;
    if (all_out() !== '0) begin
      failures++; $display("FAIL reset_outs got=%h exp=0", all_out());
    end
    cycle();
    checks++;
    if (all_out() !== '0) begin
      failures++; $display("FAIL reset_hold got=%h exp=0", all_out());
    end
    start = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
  endtask

  // 1 filter, 1x1 output, stride 1, full-rate input; start at c=0.
  task automatic run_basic(input string tag);
    logic [7:0] e;
    logic [3:0] we;
    set_cfg(1, 1, 1, 1); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c <= 37; c++) begin
      start = (c == 0);
      #2;
      e = (c == 0) ? CIdle : (c <= 12) ? CLdF : (c <= 24) ? CLdR : (c == 25) ? CAcc :
          (c <= 34) ? CMac : (c == 35) ? CWr : (c == 36) ? CDn : CIdle;
      checks++;
      if (ctl() !== e) begin
        failures++; $display("FAIL %s_ctl c=%0d got=%b exp=%b", tag, c, ctl(), e);
      end
      if (c >= 1 && c <= 24) begin
        we = 4'b1000 >> ((c - 1) % 4);
        checks++;
        if (slice_we !== we || buf_sel !== 2'(((c - 1) % 12) / 4)) begin
          failures++; $display("FAIL %s_load c=%0d got=%b/%0d exp=%b/%0d", tag, c, slice_we,
                               buf_sel, we, ((c - 1) % 12) / 4);
        end
      end
      if (c >= 26 && c <= 34) begin
        checks++;
        if ({tap_row, tap_col} !== {2'((c - 26) / 3), 2'((c - 26) % 3)}) begin
          failures++; $display("FAIL %s_tap c=%0d got=%0d,%0d exp=%0d,%0d", tag, c, tap_row,
                               tap_col, (c - 26) / 3, (c - 26) % 3);
        end
      end
      if (c == 35) begin
        checks++;
        if ({out_filt, out_row, out_col} !== 19'd0) begin
          failures++; $display("FAIL %s_pos got=%0d,%0d,%0d exp=0,0,0", tag, out_filt, out_row,
                               out_col);
        end
      end
      cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] e;
    do_reset();
    set_cfg(1, 1, 1, 1); in_valid = 1'b1;
    for (int c = 0; c <= 42; c++) begin
      // a start (with an illegal stride) while busy must be ignored
      start      = (c == 0) || (c >= 36 && c <= 39);
      cfg_stride = (c >= 36 && c <= 39) ? 2'd0 : 2'd1;
      out_ready  = !(c >= 35 && c <= 39);
      #2;
      if (c >= 35) begin
        e = (c <= 40) ? CWr : (c == 41) ? CDn : CIdle;
        checks++;
        if (ctl() !== e || cfg_err !== 1'b0) begin
          failures++; $display("FAIL stall_ctl c=%0d got=%b/%b exp=%b/0", c, ctl(), cfg_err, e);
        end
        if (c <= 40) begin
          checks++;
          if ({out_filt, out_row, out_col} !== 19'd0) begin
            failures++; $display("FAIL stall_pos c=%0d got=%0d,%0d,%0d exp=0,0,0", c, out_filt,
                                 out_row, out_col);
          end
        end
      end
      cycle();
    end
    start = 1'b0; cfg_stride = 2'd1;
  endtask

  task automatic test_shift();
    logic [7:0] e;
    do_reset();
    set_cfg(1, 2, 1, 1); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c <= 49; c++) begin
      start = (c == 0);
      #2;
      if (c >= 35) begin
        e = (c == 35) ? CWr : (c == 36) ? CSh : (c == 37) ? CAcc : (c <= 46) ? CMac :
            (c == 47) ? CWr : (c == 48) ? CDn : CIdle;
        checks++;
        if (ctl() !== e) begin
          failures++; $display("FAIL shift_ctl c=%0d got=%b exp=%b", c, ctl(), e);
        end
      end
      if (c == 47) begin
        checks++;
        if ({out_filt, out_row, out_col} !== {3'd0, 8'd0, 8'd1}) begin
          failures++; $display("FAIL shift_pos got=%0d,%0d,%0d exp=0,0,1", out_filt, out_row,
                               out_col);
        end
      end
      cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_gaps();
    int np;
    logic [3:0] we;
    do_reset();
    set_cfg(1, 1, 1, 1); out_ready = 1'b1; np = 0;
    for (int c = 0; c <= 61; c++) begin
      start    = (c == 0);
      in_valid = (c % 2 == 1);
      #2;
      if (!in_valid) begin
        checks++;
        if (slice_we !== 4'd0) begin
          failures++; $display("FAIL gaps_idle_we c=%0d got=%b exp=0000", c, slice_we);
        end
      end else if (slice_we !== 4'd0) begin
        we = 4'b1000 >> (np % 4);
        checks++;
        if (slice_we !== we || ld_filt !== (np < 12)) begin
          failures++; $display("FAIL gaps_order pulse=%0d got=%b/%b exp=%b/%b", np, slice_we,
                               ld_filt, we, np < 12);
        end
        np++;
      end
      if (c == 48 || c == 58 || c == 59) begin
        checks++;
        if (ctl() !== ((c == 48) ? CAcc : (c == 58) ? CWr : CDn)) begin
          failures++; $display("FAIL gaps_ctl c=%0d got=%b", c, ctl());
        end
      end
      cycle();
    end
    checks++;
    if (np != 24) begin
      failures++; $display("FAIL gaps_count got=%0d exp=24", np);
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stride2();
    logic [7:0] e;
    int nb;
    do_reset();
    set_cfg(2, 1, 1, 2); in_valid = 1'b1; out_ready = 1'b1; nb = 0;
    for (int c = 0; c <= 56; c++) begin
      start = (c == 0);
      #2;
      e = (c == 0) ? CIdle : (c <= 12) ? CLdF : (c <= 24) ? CLdR : (c == 25) ? CAcc :
          (c <= 34) ? CMac : (c == 35) ? CWr : (c <= 43) ? CLdR : (c == 44) ? CAcc :
          (c <= 53) ? CMac : (c == 54) ? CWr : (c == 55) ? CDn : CIdle;
      checks++;
      if (ctl() !== e) begin
        failures++; $display("FAIL s2_ctl c=%0d got=%b exp=%b", c, ctl(), e);
      end
      if (c >= 13 && c <= 24) begin
        checks++;
        if (buf_sel !== 2'((c - 13) / 4)) begin
          failures++; $display("FAIL s2_buf1 c=%0d got=%0d exp=%0d", c, buf_sel, (c - 13) / 4);
        end
      end
      if (c >= 36 && c <= 43) begin
        if (slice_we !== 4'd0) nb++;
        checks++;
        if (buf_sel !== ((c < 40) ? 2'd3 : 2'd0)) begin
          failures++; $display("FAIL s2_buf2 c=%0d got=%0d exp=%0d", c, buf_sel,
                               (c < 40) ? 3 : 0);
        end
      end
      if (c == 30 || c == 44 || c == 54) begin
        checks++;
        if (win_base !== ((c == 30) ? 2'd0 : 2'd2)) begin
          failures++; $display("FAIL s2_win_base c=%0d got=%0d exp=%0d", c, win_base,
                               (c == 30) ? 0 : 2);
        end
      end
      if (c == 35 || c == 54) begin
        checks++;
        if ({out_filt, out_row, out_col} !== {3'd0, 8'((c == 54) ? 1 : 0), 8'd0}) begin
          failures++; $display("FAIL s2_pos c=%0d got=%0d,%0d,%0d", c, out_filt, out_row,
                               out_col);
        end
      end
      cycle();
    end
    checks++;
    if (nb != 8) begin
      failures++; $display("FAIL s2_beats got=%0d exp=8", nb);
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    do_reset();
    set_cfg(1, 1, 2, 1); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c <= 72; c++) begin
      start = (c == 0);
      #2;
      e = (c == 0) ? CIdle : (c <= 12) ? CLdF : (c <= 24) ? CLdR : (c == 25) ? CAcc :
          (c <= 34) ? CMac : (c == 35) ? CWr : (c <= 47) ? CLdF : (c <= 59) ? CLdR :
          (c == 60) ? CAcc : (c <= 69) ? CMac : (c == 70) ? CWr : (c == 71) ? CDn : CIdle;
      checks++;
      if (ctl() !== e) begin
        failures++; $display("FAIL b2b_ctl c=%0d got=%b exp=%b", c, ctl(), e);
      end
      if (c >= 36 && c <= 59) begin
        checks++;
        if (buf_sel !== 2'(((c - 36) % 12) / 4)) begin
          failures++; $display("FAIL b2b_buf c=%0d got=%0d exp=%0d", c, buf_sel,
                               ((c - 36) % 12) / 4);
        end
      end
      if (c == 60) begin
        checks++;
        if (win_base !== 2'd0) begin
          failures++; $display("FAIL b2b_win_base got=%0d exp=0", win_base);
        end
      end
      if (c == 70) begin
        checks++;
        if ({out_filt, out_row, out_col} !== {3'd1, 8'd0, 8'd0}) begin
          failures++; $display("FAIL b2b_pos got=%0d,%0d,%0d exp=1,0,0", out_filt, out_row,
                               out_col);
        end
      end
      cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_cfg_err();
    int bad [5][4] = '{'{1, 1, 1, 0}, '{0, 1, 1, 1}, '{1, 0, 1, 1}, '{1, 1, 0, 1},
                       '{1, 1, 9, 1}};
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      set_cfg(bad[t][0], bad[t][1], bad[t][2], bad[t][3]);
      for (int c = 0; c <= 3; c++) begin
        start = (c == 0);
        #2;
        if (c >= 1) begin
          checks++;
          if (ctl() !== ((c == 1) ? CDn : CIdle) || cfg_err !== 1'b1) begin
            failures++; $display("FAIL cfg_err t=%0d c=%0d got=%b/%b exp=%b/1", t, c, ctl(),
                                 cfg_err, (c == 1) ? CDn : CIdle);
          end
        end
        cycle();
      end
    end
    set_cfg(1, 1, 1, 1); start = 1'b1;
    cycle();
    start = 1'b0;
    #2;
    checks++;
    if (cfg_err !== 1'b0 || ctl() !== CLdF) begin
      failures++; $display("FAIL cfg_err_clear got=%b/%b exp=0/%b", cfg_err, ctl(), CLdF);
    end
    cycle();
    set_cfg(1, 1, 1, 0); start = 1'b1;
    do_reset();
    set_cfg(1, 1, 1, 0); start = 1'b1;
    cycle();
    start = 1'b0; rst = 1'b1;
    #2;
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++; $display("FAIL cfg_err_rst got=%b exp=0", cfg_err);
    end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    set_cfg(1, 1, 1, 1); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      start = (c == 0);
      #2;
      if (c == 30) begin
        checks++;
        if (ctl() !== CMac) begin
          failures++; $display("FAIL mid_mac_ctl got=%b exp=%b", ctl(), CMac);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_out() !== '0) begin
          failures++; $display("FAIL mid_mac_rst got=%h exp=0", all_out());
        end
      end
      cycle();
    end
    rst = 1'b0;
    run_basic("post_rst");
  endtask

  initial begin
    test_reset();
    run_basic("basic");
    test_stall();
    test_shift();
    test_gaps();
    test_stride2();
    test_back_to_back();
    test_cfg_err();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- K, 3, square kernel size (rows = cols = taps per side)
- SLICES, 4, slices per row word; one accepted beat per slice
- N_BUF, 4, ifmap row buffers, circular; N_BUF >= K
- MAX_F, 8, maximum filters per run
- CNT_W, 8, width of size/count configuration fields
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 Ports SHALL be, one per line:
- clk in 1 clock
- rst in 1 async active-high reset
- start in 1 run request pulse
- cfg_out_rows in CNT_W output rows
- cfg_out_cols in CNT_W output columns
- cfg_num_filt in $clog2(MAX_F)+1 filter count
- cfg_stride in 2 stride, 1..K
- in_valid in 1 slice beat valid
- in_ready out 1 block accepts a beat
- ld_filt out 1 current beat targets filter storage (else ifmap)
- buf_sel out $clog2(N_BUF) target row buffer
- slice_we out SLICES one-hot slice write enable
- win_base out $clog2(N_BUF) buffer holding window top row
- tap_row out $clog2(K) tap row offset
- tap_col out $clog2(K) tap column
- win_shift out 1 shift window one column
- acc_clr out 1 clear accumulator
- mac_en out 1 accumulate current tap
- out_valid out 1 result ready
- out_ready in 1 consumer accepts result
- out_filt out $clog2(MAX_F) filter index of result
- out_row out CNT_W output row of result
- out_col out CNT_W output column of result
- busy out 1 run in progress
- done out 1 one-cycle end-of-run pulse
- cfg_err out 1 last start had illegal config

Function
REQ-004 States SHALL be IDLE, LD_FILT, LD_ROW, ACC_CLR, MAC, WRITE, SHIFT, DONE.
REQ-005 In IDLE, start=1 SHALL capture all cfg_* and move to LD_FILT; start outside IDLE SHALL be ignored.
REQ-006 Illegal config (any of out_rows, out_cols, num_filt = 0; num_filt > MAX_F; stride = 0 or > K) SHALL set cfg_err, go to DONE, accept no beats; a legal start SHALL clear cfg_err.
REQ-007 in_ready SHALL be 1 only in LD_FILT/LD_ROW; a beat is accepted on in_valid&&in_ready; slice_we SHALL be nonzero only on accepted beats, slice order SLICES-1 down to 0.
REQ-008 LD_FILT SHALL accept K*SLICES beats (ld_filt=1, buf_sel = filter row), then go to LD_ROW.
REQ-009 LD_ROW SHALL accept K*SLICES beats for the first output row of each filter and cfg_stride*SLICES beats otherwise; buf_sel advances mod N_BUF per row; win_base then advances by cfg_stride mod N_BUF (not on first load).
REQ-010 ACC_CLR SHALL last one cycle (acc_clr=1), then MAC for exactly K*K cycles, mac_en=1, tap_row outer / tap_col inner, each 0..K-1.
REQ-011 WRITE SHALL hold out_valid=1 with stable out_filt/out_row/out_col until out_ready=1; nothing else advances while stalled.
REQ-012 After the WRITE handshake: more columns -> SHIFT (win_shift=1 for cfg_stride cycles) -> ACC_CLR; else more rows -> LD_ROW; else more filters -> LD_FILT (row/col reset to 0, win_base reset to 0); else DONE.
REQ-013 DONE SHALL last one cycle with done=1, then IDLE; busy SHALL be 1 in every state except IDLE and DONE.

Reset
REQ-014 rst SHALL force IDLE immediately, zero all counters, and drive every output 0 (cfg_err included); an in-flight beat is discarded; a start in the first cycle after release SHALL be honoured.

Structure
REQ-015 State encoding and the cfg-legality limits SHALL live in the shared package cnn_pkg.
REQ-016 Tap/slice/position counting SHALL use one sub-module, wrap_counter (parametric modulus, en, clr, wrap flag), instantiated per counter.

Verification
REQ-017 K=3, SLICES=4, 1 filter, 1x1 output, stride 1, in_valid=1, out_ready=1, start at cycle 0 -> filter beats cycles 1-12, row beats 13-24, acc_clr 25, mac_en 26-34, out_valid 35 (0,0,0), done 36.
REQ-018 out_ready=0 for 5 cycles at first WRITE -> out_valid and out_* stable 6 cycles, no mac_en/in_ready, ACC_CLR or DONE on the cycle after acceptance.
REQ-019 in_valid alternating 1/0 during loads -> exactly 12 slice_we pulses per load, order 1000,0100,0010,0001 per row.
REQ-020 stride 2, out_rows 2, out_cols 1, N_BUF 4 -> first load buf_sel 0,1,2; second load 8 beats to buffers 3,0; win_base 2; outputs (0,0,0),(0,1,0).
REQ-021 start with cfg_stride=0 -> cfg_err=1, in_ready never 1, done pulses cycle 1.
REQ-022 rst asserted mid-MAC -> all outputs 0 that cycle; a new legal start after release runs REQ-017 timing exactly.
